// File: rtl/uart_ascii_digit_buffer_pkg.sv
// Shared character codes, character classes and FSM states for the UART
// ASCII digit line-edit buffer.
package uart_ascii_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_BS   = 8'h08;
    localparam logic [7:0] ASCII_DEL  = 8'h7F;
    localparam logic [7:0] ASCII_ESC  = 8'h1B;
    localparam logic [7:0] ASCII_CR   = 8'h0D;

    typedef enum logic [2:0] {
        CC_HEX,
        CC_BS,
        CC_ESC,
        CC_CR,
        CC_OTHER
    } char_class_e;

    typedef enum logic {
        S_EDIT,
        S_COMMIT
    } state_e;

endpackage

// File: rtl/uart_ascii_digit_buffer_classifier.sv
// Combinational classifier: sorts a received byte into an editing action and
// folds lowercase hex letters onto their uppercase form.
module ascii_char_classifier
    import uart_ascii_pkg::*;
(
    input  logic [7:0]  rx_data,
    output char_class_e char_class,
    output logic [7:0]  norm_data
);

    always_comb begin
        char_class = CC_OTHER;
        norm_data  = rx_data;
        if ((rx_data >= 8'h30 && rx_data <= 8'h39) ||
            (rx_data >= 8'h41 && rx_data <= 8'h46)) begin
            char_class = CC_HEX;
        end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
            char_class = CC_HEX;
            norm_data  = rx_data - 8'h20;
        end else if (rx_data == ASCII_BS || rx_data == ASCII_DEL) begin
            char_class = CC_BS;
        end else if (rx_data == ASCII_ESC) begin
            char_class = CC_ESC;
        end else if (rx_data == ASCII_CR) begin
            char_class = CC_CR;
        end
    end

endmodule

// File: rtl/uart_ascii_digit_buffer.sv
// N-digit ASCII hex line-edit buffer fed by UART RX bytes; carriage return
// publishes the working buffer to the display register.
module uart_ascii_digit_buffer
    import uart_ascii_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    output logic                              rx_ready,
    output logic [8*NUM_DIGITS-1:0]           edit_ascii,
    output logic [8*NUM_DIGITS-1:0]           digits_ascii,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic                              commit_pulse,
    output logic                              err_pulse
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(NUM_DIGITS);
    localparam logic [8*NUM_DIGITS-1:0] ALL_ZERO = {NUM_DIGITS{ASCII_ZERO}};

    state_e                  state_q,  state_d;
    logic [8*NUM_DIGITS-1:0] edit_q,   edit_d;
    logic [8*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [CW-1:0]           count_q,  count_d;
    logic                    err_q,    err_d;

    char_class_e char_class;
    logic [7:0]  norm_data;
    logic        accept;

    ascii_char_classifier u_classifier (
        .rx_data    (rx_data),
        .char_class (char_class),
        .norm_data  (norm_data)
    );

    // Reset gates the handshake and the commit strobe so an aborted commit never shows.
    assign rx_ready     = (state_q == S_EDIT) && !rst;
    assign commit_pulse = (state_q == S_COMMIT) && !rst;
    assign err_pulse    = err_q;
    assign edit_ascii   = edit_q;
    assign digits_ascii = digits_q;
    assign digit_count  = count_q;
    assign accept       = rx_valid && rx_ready;

    always_comb begin
        state_d  = state_q;
        edit_d   = edit_q;
        digits_d = digits_q;
        count_d  = count_q;
        err_d    = 1'b0;
        case (state_q)
            S_EDIT: begin
                if (accept) begin
                    case (char_class)
                        CC_HEX: begin
                            if (count_q != FULL_CNT) begin
                                edit_d  = {edit_q[8*NUM_DIGITS-9:0], norm_data};
                                count_d = count_q + CW'(1);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CC_BS: begin
                            if (count_q != '0) begin
                                edit_d  = {ASCII_ZERO, edit_q[8*NUM_DIGITS-1:8]};
                                count_d = count_q - CW'(1);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CC_ESC: begin
                            edit_d  = ALL_ZERO;
                            count_d = '0;
                        end
                        CC_CR: begin
                            digits_d = edit_q;
                            state_d  = S_COMMIT;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_COMMIT: begin
                // The working buffer is cleared only after the committed copy is visible.
                edit_d  = ALL_ZERO;
                count_d = '0;
                state_d = S_EDIT;
            end
            default: state_d = S_EDIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_EDIT;
            edit_q   <= ALL_ZERO;
            digits_q <= ALL_ZERO;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            edit_q   <= edit_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

endmodule
